bus_cycle_scheduler: RTL and testbench
======================================

# bus_cycle_scheduler

Sequences the 8088 bus interface's T-state machine and chooses which requester owns each bus cycle: prefetch-queue fill, EU indirect (memory/IO) transfer, interrupt-acknowledge pair, or HOLD. It sits inside the bus interface unit, between the EU request lines (indirect, irq, suspend, flush) and the pin-level cycle generator. It splits EU word transfers into two byte cycles, and it reports progress back to the EU.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  bus clock. One clock: everything is on the rising edge of CLK.
- RESET  in  1  synchronous, active-high reset.
- READY  in  1  memory ready. Sampled in T3/TW.
- HOLD  in  1  external bus hold request.
- prefetchFull  in  1  prefetch queue has no free slot.
- flush  in  1  one-clock pulse: queue discarded.
- suspend  in  1  level: EU forbids new prefetch cycles.
- indirect  in  1  one-clock pulse: EU transfer request.
- ind_ioMreq, ind_readWrite, ind_byteWord  in  1 each  transfer attributes, valid with `indirect`:
  - ind_ioMreq: 1 = IO.
  - ind_readWrite: 1 = write.
  - ind_byteWord: 1 = word.
- irq  in  1  one-clock pulse: run the INTA pair.
- tState  out  3  0=TI, 1=T1, 2=T2, 3=T3, 4=TW, 5=T4, 6=TH.
- cycleKind  out  2  0=prefetch, 1=indirect, 2=INTA. Stable T1..T4.
- cycleIoM, cycleWrite  out  1 each  current cycle attributes (INTA: IoM=1, Write=0).
- byteIndex  out  1  0 for the low byte / first INTA, 1 for the high byte / second INTA.
- cycleEnd  out  1  pulse during T4 of every cycle.
- discardFetch  out  1  current prefetch data must not enter the queue.
- indirectBusOpInProgress  out  1  indirect request accepted and not yet finished.
- indDone, intaDone  out  1 each  pulse in T4 of the final cycle of the sequence.
- suspending  out  1  suspend asserted while a prefetch cycle is still running.
- HOLDA  out  1  hold acknowledge.

## Operation
- A decision point is any clock in TI or T4. The next state is T1 (new cycle), TH, or TI.
- Priority at a decision point:
  1. Locked continuation: second byte of a word transfer, or second INTA.
  2. HOLD.
  3. Pending indirect.
  4. Pending INTA.
  5. Prefetch, only if !prefetchFull && !suspend && !flush this clock.
  6. Otherwise TI.
- Locked sequences: HOLD is never granted between the two halves of a word transfer or between the two INTA cycles.
- Request latching:
  - `indirect` latches the attributes into a pending slot. This happens in any state.
  - `irq` sets an INTA-pending flag.
  - The EU never issues a second indirect while indirectBusOpInProgress=1. The block ignores one if it arrives.
- Cycle sequence: T1→T2→T3.
  - In T3 or TW: READY=0 → TW; READY=1 → T4.
- Word transfer: two consecutive cycles, byteIndex 0 then 1, with no TI between them.
- indirectBusOpInProgress:
  - Rises the clock after the `indirect` pulse.
  - Falls after T4 of the final byte, on the same edge that indDone ends.
- HOLD handling: a decision point with HOLD=1 → TH, with HOLDA=1 for as long as the state is TH. HOLD=0 in TH → TI next clock, HOLDA=0.
- flush during a prefetch cycle (T1..T4):
  - discardFetch=1 from the next clock through that cycle's T4.
  - The cycle itself completes normally.
  - flush never aborts an indirect or INTA cycle.
- suspending:
  - Asserts when suspend=1 and cycleKind=prefetch with tState in T1..T4.
  - Deasserts after T4 of that cycle.
  - Stays 0 if no prefetch cycle is running.
- indirect and irq in the same clock: both are latched, and the indirect is served first.
- RESET: state TI, all pending flags cleared. All outputs are 0, including:
  - tState=0, cycleKind=0, HOLDA=0.
  - discardFetch, suspending and every pulse output.

  Reset mid-cycle abandons the cycle immediately, with no indDone or intaDone.

## Timing
- Zero-wait cycle = 4 clocks. Each wait state adds 1 clock.
- Idle with a request present: TI(decision) → T1 on the next clock.
- Back-to-back cycles: T4 → T1 with no TI between them.
- Latency from `indirect` pulse to T1:
  - Bus idle: 1 clock, if the pulse arrives in TI.
  - Otherwise: the clock after the T4 of the running cycle.
- Word transfer, zero wait: indDone exactly 8 clocks after the first T1.
- A HOLD raised during T2 is granted at the next decision point: TH entered after T4. HOLDA rises on that entry clock.
- All outputs are registered except the cycleEnd, indDone and intaDone pulses. Those three are decoded from the registered state.

## Configuration
- BUS_SCHED_HOLD_EN defined:
  - HOLD/HOLDA arbitration works as described.
  - TH is reachable.
- Not defined:
  - HOLD is ignored and HOLDA is tied 0.
  - TH is never entered and tState never reads 6.

## Test plan
- Reset, queue not full, suspend=0, READY=1 → tState sequence 0,1,2,3,5,1,… with cycleKind=0 and cycleEnd every 4 clocks. Stops in TI once prefetchFull=1.
- indirect (word write, IO) in TI → two cycles with byteIndex 0/1 and cycleWrite=1, cycleIoM=1. indDone 8 clocks after the first T1; indirectBusOpInProgress falls the same edge indDone ends.
- READY=0 for 3 clocks from T3 → three TW states, then T4. Cycle length 7.
- irq and HOLD together during a prefetch T2:
  - TH entered after T4, HOLDA=1.
  - HOLD=0 → TI.
  - Then two locked INTA cycles; a HOLD raised during the first is deferred until after intaDone.
- flush during prefetch T2 → discardFetch=1 through T4, then 0. The next decision starts a fresh prefetch when suspend=0.
- RESET asserted in T3 of an indirect cycle → next clock tState=0, indirectBusOpInProgress=0, no indDone.

Source files
------------

// File: rtl/bus_cycle_scheduler.sv
// bus_cycle_scheduler
// Sequences the 8088 bus T-states and chooses which requester owns each bus
// cycle: prefetch, EU indirect transfer (split into byte cycles), the
// interrupt-acknowledge pair, or HOLD.
// Optional feature macro: BUS_SCHED_HOLD_EN enables HOLD/HOLDA arbitration and
// the TH state. Without it HOLD is ignored and HOLDA stays 0.
module bus_cycle_scheduler (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       READY,
    input  logic       HOLD,
    input  logic       prefetchFull,
    input  logic       flush,
    input  logic       suspend,
    input  logic       indirect,
    input  logic       ind_ioMreq,
    input  logic       ind_readWrite,
    input  logic       ind_byteWord,
    input  logic       irq,
    output logic [2:0] tState,
    output logic [1:0] cycleKind,
    output logic       cycleIoM,
    output logic       cycleWrite,
    output logic       byteIndex,
    output logic       cycleEnd,
    output logic       discardFetch,
    output logic       indirectBusOpInProgress,
    output logic       indDone,
    output logic       intaDone,
    output logic       suspending,
    output logic       HOLDA
);

    localparam logic [2:0] S_TI = 3'd0;
    localparam logic [2:0] S_T1 = 3'd1;
    localparam logic [2:0] S_T2 = 3'd2;
    localparam logic [2:0] S_T3 = 3'd3;
    localparam logic [2:0] S_TW = 3'd4;
    localparam logic [2:0] S_T4 = 3'd5;
    localparam logic [2:0] S_TH = 3'd6;

    localparam logic [1:0] K_PF   = 2'd0;
    localparam logic [1:0] K_IND  = 2'd1;
    localparam logic [1:0] K_INTA = 2'd2;

    // Bus state and attributes of the cycle currently owning the bus
    logic [2:0] tstate_q, tstate_d;
    logic [1:0] kind_q, kind_d;
    logic       iom_q, iom_d;
    logic       write_q, write_d;
    logic       word_q, word_d;
    logic       byte_q, byte_d;

    // Pending requests
    logic       ind_pend_q, ind_pend_d;
    logic       ind_iom_q, ind_iom_d;
    logic       ind_write_q, ind_write_d;
    logic       ind_word_q, ind_word_d;
    logic       inta_pend_q, inta_pend_d;

    // Registered status outputs
    logic       busy_q, busy_d;
    logic       discard_q, discard_d;
    logic       susp_q, susp_d;
    logic       holda_q, holda_d;

    // Decoded helpers
    logic       hold_req;
    logic       ind_take;
    logic       ind_avail;
    logic       inta_avail;
    logic       sel_iom, sel_write, sel_word;
    logic       locked;
    logic       start_ind, start_inta;
    logic       in_cycle;
    logic       cycle_end, ind_done, inta_done;

`ifdef BUS_SCHED_HOLD_EN
    assign hold_req = HOLD;
`else
    assign hold_req = HOLD & 1'b0;
`endif

    // A second indirect while one is outstanding is dropped.
    assign ind_take   = indirect && !busy_q;
    assign ind_avail  = ind_pend_q || ind_take;
    assign inta_avail = inta_pend_q || irq;
    // A request arriving this very clock bypasses the pending slot.
    assign sel_iom    = ind_take ? ind_ioMreq    : ind_iom_q;
    assign sel_write  = ind_take ? ind_readWrite : ind_write_q;
    assign sel_word   = ind_take ? ind_byteWord  : ind_word_q;
    // Second half of a word transfer or second INTA must follow immediately.
    assign locked     = (tstate_q == S_T4) && !byte_q &&
                        (((kind_q == K_IND) && word_q) || (kind_q == K_INTA));
    // T1..TW: cycle running and not in its last clock
    assign in_cycle   = (tstate_q == S_T1) || (tstate_q == S_T2) ||
                        (tstate_q == S_T3) || (tstate_q == S_TW);

    // State register: all state and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tstate_q    <= S_TI;
            kind_q      <= K_PF;
            iom_q       <= 1'b0;
            write_q     <= 1'b0;
            word_q      <= 1'b0;
            byte_q      <= 1'b0;
            ind_pend_q  <= 1'b0;
            ind_iom_q   <= 1'b0;
            ind_write_q <= 1'b0;
            ind_word_q  <= 1'b0;
            inta_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            discard_q   <= 1'b0;
            susp_q      <= 1'b0;
            holda_q     <= 1'b0;
        end else begin
            tstate_q    <= tstate_d;
            kind_q      <= kind_d;
            iom_q       <= iom_d;
            write_q     <= write_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            ind_pend_q  <= ind_pend_d;
            ind_iom_q   <= ind_iom_d;
            ind_write_q <= ind_write_d;
            ind_word_q  <= ind_word_d;
            inta_pend_q <= inta_pend_d;
            busy_q      <= busy_d;
            discard_q   <= discard_d;
            susp_q      <= susp_d;
            holda_q     <= holda_d;
        end
    end

    // Next-state: T-state progression and bus ownership at decision points
    always_comb begin
        tstate_d   = tstate_q;
        kind_d     = kind_q;
        iom_d      = iom_q;
        write_d    = write_q;
        word_d     = word_q;
        byte_d     = byte_q;
        start_ind  = 1'b0;
        start_inta = 1'b0;
        case (tstate_q)
            S_TI, S_T4: begin
                if (locked) begin
                    tstate_d = S_T1;
                    byte_d   = 1'b1;
                end else if (hold_req) begin
                    tstate_d = S_TH;
                end else if (ind_avail) begin
                    tstate_d  = S_T1;
                    kind_d    = K_IND;
                    iom_d     = sel_iom;
                    write_d   = sel_write;
                    word_d    = sel_word;
                    byte_d    = 1'b0;
                    start_ind = 1'b1;
                end else if (inta_avail) begin
                    tstate_d   = S_T1;
                    kind_d     = K_INTA;
                    iom_d      = 1'b1;
                    write_d    = 1'b0;
                    word_d     = 1'b0;
                    byte_d     = 1'b0;
                    start_inta = 1'b1;
                end else if (!prefetchFull && !suspend && !flush) begin
                    tstate_d = S_T1;
                    kind_d   = K_PF;
                    iom_d    = 1'b0;
                    write_d  = 1'b0;
                    word_d   = 1'b0;
                    byte_d   = 1'b0;
                end else begin
                    tstate_d = S_TI;
                end
            end
            S_T1:       tstate_d = S_T2;
            S_T2:       tstate_d = S_T3;
            S_T3, S_TW: tstate_d = READY ? S_T4 : S_TW;
            S_TH:       tstate_d = hold_req ? S_TH : S_TI;
            default:    tstate_d = S_TI;
        endcase
    end

    // Outputs: request bookkeeping, status flags and T4 pulses
    always_comb begin
        cycle_end   = (tstate_q == S_T4);
        ind_done    = cycle_end && (kind_q == K_IND) && (byte_q || !word_q);
        inta_done   = cycle_end && (kind_q == K_INTA) && byte_q;
        ind_pend_d  = ind_avail && !start_ind;
        ind_iom_d   = sel_iom;
        ind_write_d = sel_write;
        ind_word_d  = sel_word;
        inta_pend_d = inta_avail && !start_inta;
        busy_d      = busy_q;
        if (ind_take) begin
            busy_d = 1'b1;
        end else if (ind_done) begin
            busy_d = 1'b0;
        end
        // Both flags stick until the prefetch cycle leaves T4.
        discard_d = in_cycle && (kind_q == K_PF) && (discard_q || flush);
        susp_d    = in_cycle && (kind_q == K_PF) && (susp_q || suspend);
        holda_d   = (tstate_d == S_TH);
    end

    assign tState                  = tstate_q;
    assign cycleKind               = kind_q;
    assign cycleIoM                = iom_q;
    assign cycleWrite              = write_q;
    assign byteIndex               = byte_q;
    assign cycleEnd                = cycle_end;
    assign discardFetch            = discard_q;
    assign indirectBusOpInProgress = busy_q;
    assign indDone                 = ind_done;
    assign intaDone                = inta_done;
    assign suspending              = susp_q;
    assign HOLDA                   = holda_q;

endmodule

// File: tb/tb_bus_cycle_scheduler.sv
// Bench for bus_cycle_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every clock against a transaction-level model.
module tb_bus_cycle_scheduler;

`ifdef BUS_SCHED_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b1, READY = 1'b1, HOLD = 1'b0, prefetchFull = 1'b1;
    logic flush = 1'b0, suspend = 1'b0, indirect = 1'b0, irq = 1'b0;
    logic ind_ioMreq = 1'b0, ind_readWrite = 1'b0, ind_byteWord = 1'b0;
    logic [2:0] tState;
    logic [1:0] cycleKind;
    logic cycleIoM, cycleWrite, byteIndex, cycleEnd, discardFetch;
    logic indirectBusOpInProgress, indDone, intaDone, suspending, HOLDA;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    bus_cycle_scheduler dut (
        .CLK(CLK), .RESET(RESET), .READY(READY), .HOLD(HOLD),
        .prefetchFull(prefetchFull), .flush(flush), .suspend(suspend),
        .indirect(indirect), .ind_ioMreq(ind_ioMreq),
        .ind_readWrite(ind_readWrite), .ind_byteWord(ind_byteWord), .irq(irq),
        .tState(tState), .cycleKind(cycleKind), .cycleIoM(cycleIoM),
        .cycleWrite(cycleWrite), .byteIndex(byteIndex), .cycleEnd(cycleEnd),
        .discardFetch(discardFetch),
        .indirectBusOpInProgress(indirectBusOpInProgress),
        .indDone(indDone), .intaDone(intaDone), .suspending(suspending),
        .HOLDA(HOLDA)
    );

    // ---------------- reference model ----------------
    // A request is expanded into its list of bus cycles when it wins the bus;
    // cycles left in that list are a locked continuation.
    typedef struct packed {
        bit [1:0] kind;
        bit       iom;
        bit       wr;
        bit       idx;
        bit       last;
    } cyc_t;

    cyc_t seq_q[$];
    cyc_t m_cur;
    int   m_t;
    bit   m_ind_pend, m_ind_iom, m_ind_wr, m_ind_word, m_inta_pend;
    bit   m_busy, m_disc, m_susp;

    function automatic cyc_t mk(bit [1:0] k, bit iom, bit wr, bit idx, bit last);
        cyc_t c;
        c.kind = k; c.iom = iom; c.wr = wr; c.idx = idx; c.last = last;
        return c;
    endfunction

    always @(posedge CLK) begin
        int   nt;
        cyc_t nc;
        bit   took, ind_av, inta_av, st_ind, st_inta, running, fin;
        if (RESET) begin
            seq_q.delete();
            m_cur = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            m_t = 0;
            m_ind_pend = 0; m_ind_iom = 0; m_ind_wr = 0; m_ind_word = 0;
            m_inta_pend = 0; m_busy = 0; m_disc = 0; m_susp = 0;
        end else begin
            took = indirect && !m_busy;
            if (took) begin
                m_ind_iom = ind_ioMreq; m_ind_wr = ind_readWrite; m_ind_word = ind_byteWord;
            end
            ind_av  = m_ind_pend || took;
            inta_av = m_inta_pend || irq;
            st_ind = 0; st_inta = 0;
            running = (m_t >= 1) && (m_t <= 4);
            fin = (m_t == 5) && (m_cur.kind == 2'd1) && m_cur.last;
            nt = m_t; nc = m_cur;
            if (m_t == 0 || m_t == 5) begin
                if (seq_q.size() > 0) begin
                    nc = seq_q.pop_front(); nt = 1;
                end else if (HOLD_EN && HOLD) begin
                    nt = 6;
                end else if (ind_av) begin
                    if (m_ind_word) begin
                        seq_q.push_back(mk(2'd1, m_ind_iom, m_ind_wr, 1'b0, 1'b0));
                        seq_q.push_back(mk(2'd1, m_ind_iom, m_ind_wr, 1'b1, 1'b1));
                    end else begin
                        seq_q.push_back(mk(2'd1, m_ind_iom, m_ind_wr, 1'b0, 1'b1));
                    end
                    nc = seq_q.pop_front(); nt = 1; st_ind = 1;
                end else if (inta_av) begin
                    seq_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
                    seq_q.push_back(mk(2'd2, 1'b1, 1'b0, 1'b1, 1'b1));
                    nc = seq_q.pop_front(); nt = 1; st_inta = 1;
                end else if (!prefetchFull && !suspend && !flush) begin
                    nc = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1); nt = 1;
                end else begin
                    nt = 0;
                end
            end else if (m_t == 1) nt = 2;
            else if (m_t == 2) nt = 3;
            else if (m_t == 3 || m_t == 4) nt = READY ? 5 : 4;
            else if (m_t == 6) nt = (HOLD_EN && HOLD) ? 6 : 0;
            m_disc = running && (m_cur.kind == 2'd0) && (m_disc || flush);
            m_susp = running && (m_cur.kind == 2'd0) && (m_susp || suspend);
            m_ind_pend  = ind_av && !st_ind;
            m_inta_pend = inta_av && !st_inta;
            if (took) m_busy = 1;
            else if (fin) m_busy = 0;
            m_t = nt; m_cur = nc;
        end
    end

    // ---------------- per-clock compare ----------------
    always @(negedge CLK) begin
        logic [14:0] act, exp;
        if (chk_en) begin
            act = {tState, cycleKind, cycleIoM, cycleWrite, byteIndex, cycleEnd,
                   discardFetch, indirectBusOpInProgress, indDone, intaDone,
                   suspending, HOLDA};
            exp = {3'(m_t), m_cur.kind, m_cur.iom, m_cur.wr, m_cur.idx, m_t == 5,
                   m_disc, m_busy, (m_t == 5) && (m_cur.kind == 2'd1) && m_cur.last,
                   (m_t == 5) && (m_cur.kind == 2'd2) && m_cur.last,
                   m_susp, m_t == 6};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL outputs t=%0t: got %h want %h (tState %0d want %0d)",
                         $time, act, exp, tState, m_t);
            end
            if (indDone === 1'b1)
                $display("[TB] t=%0t indirect done io=%0d wr=%0d", $time, cycleIoM, cycleWrite);
            if (intaDone === 1'b1)
                $display("[TB] t=%0t INTA pair done", $time);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_for(input int st, input int kind, input int budget, input string name);
        int n;
        n = 0;
        while (!(tState == 3'(st) && (kind < 0 || cycleKind == 2'(kind))) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout after %0d clocks, tState %0d want %0d", name, n, tState, st);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int seq_exp[6];
        int done_at, len, tw, rd;
        seq_exp = '{1, 2, 3, 5, 1, 2};

        // reset
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_tstate", int'(tState), 0);
        check("reset_busy", int'(indirectBusOpInProgress), 0);
        check("reset_holda", int'(HOLDA), 0);

        // free-running prefetch
        RESET = 1'b0; prefetchFull = 1'b0; READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pf_seq", int'(tState), seq_exp[i]);
            if (i == 3) check("pf_cycleEnd", int'(cycleEnd), 1);
        end
        check("pf_kind", int'(cycleKind), 0);
        prefetchFull = 1'b1;
        wait_for(0, -1, 10, "pf_stop");
        tick(); tick(); tick();
        check("pf_idle", int'(tState), 0);

        // word IO write from idle
        indirect = 1'b1; ind_ioMreq = 1'b1; ind_readWrite = 1'b1; ind_byteWord = 1'b1;
        tick();
        indirect = 1'b0; ind_ioMreq = 1'b0; ind_readWrite = 1'b0; ind_byteWord = 1'b0;
        check("word_t1", int'(tState), 1);
        check("word_busy_rise", int'(indirectBusOpInProgress), 1);
        check("word_attr", int'({cycleKind, cycleIoM, cycleWrite, byteIndex}), 5'b01110);
        done_at = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) check("word_second_byte", int'({tState, byteIndex}), 4'b0011);
            if (indDone && done_at < 0) done_at = k;
            if (k == 7) check("word_busy_at_done", int'(indirectBusOpInProgress), 1);
            if (k == 8) check("word_busy_fall", int'(indirectBusOpInProgress), 0);
        end
        // first T1 is clock 1, indDone occupies clock 8
        check("word_done_clock", done_at, 7);

        // wait states: READY low for 3 sampled clocks starting at T3
        wait_for(0, -1, 6, "tw_idle");
        indirect = 1'b1;
        tick();
        indirect = 1'b0;
        len = 1; tw = 0; rd = 0;
        for (int j = 0; j < 12; j++) begin
            if (tState == 3'd3) begin
                READY = 1'b0; rd = 3;
            end
            tick();
            len++;
            if (tState == 3'd4) tw++;
            if (rd > 0) begin
                rd--;
                if (rd == 0) READY = 1'b1;
            end
            if (tState == 3'd5) break;
        end
        READY = 1'b1;
        check("tw_length", len, 7);
        check("tw_count", tw, 3);
        check("tw_inddone", int'(indDone), 1);

        // irq + HOLD during a prefetch T2
        prefetchFull = 1'b0;
        wait_for(2, 0, 12, "inta_pf_t2");
        irq = 1'b1; HOLD = 1'b1;
        tick();
        irq = 1'b0;
        wait_for(5, 0, 8, "inta_pf_t4");
        tick();
        if (HOLD_EN) begin
            check("hold_th", int'({tState, HOLDA}), 4'b1101);
            tick();
            check("hold_stay", int'(tState), 6);
            HOLD = 1'b0;
            tick();
            check("hold_release", int'({tState, HOLDA}), 4'b0000);
            tick();
        end else begin
            check("hold_ignored", int'(HOLDA), 0);
            HOLD = 1'b0;
        end
        check("inta1_start", int'({tState, cycleKind, byteIndex}), 6'b001100);
        tick();
        HOLD = 1'b1;
        wait_for(5, 2, 8, "inta1_t4");
        tick();
        check("inta2_locked", int'({tState, cycleKind, byteIndex}), 6'b001101);
        wait_for(5, 2, 8, "inta2_t4");
        check("inta_done", int'(intaDone), 1);
        tick();
        check("hold_after_inta", int'(tState), HOLD_EN ? 6 : 1);
        HOLD = 1'b0;
        tick();

        // flush during a prefetch T2
        wait_for(2, 0, 14, "flush_t2");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_disc_t3", int'({tState, discardFetch}), 4'b0111);
        tick();
        check("flush_disc_t4", int'({tState, discardFetch}), 4'b1011);
        tick();
        check("flush_next_pf", int'({tState, cycleKind, discardFetch}), 6'b001000);

        // reset in T3 of an indirect cycle
        prefetchFull = 1'b1;
        wait_for(0, -1, 10, "rst_idle");
        indirect = 1'b1; ind_readWrite = 1'b1;
        tick();
        indirect = 1'b0; ind_readWrite = 1'b0;
        wait_for(3, 1, 6, "rst_t3");
        RESET = 1'b1;
        tick();
        check("rst_mid_state", int'({tState, indirectBusOpInProgress, indDone}), 0);
        RESET = 1'b0;
        tick();

        // randomized traffic, checked by the per-clock compare
        for (int c = 0; c < 3000; c++) begin
            READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) HOLD = ~HOLD;
            if ($urandom_range(0, 7) == 0) prefetchFull = ~prefetchFull;
            if ($urandom_range(0, 9) == 0) suspend = ~suspend;
            flush = ($urandom_range(0, 15) == 0);
            indirect = ($urandom_range(0, 11) == 0);
            ind_ioMreq = 1'($urandom_range(0, 1));
            ind_readWrite = 1'($urandom_range(0, 1));
            ind_byteWord = 1'($urandom_range(0, 1));
            irq = ($urandom_range(0, 39) == 0);
            RESET = ($urandom_range(0, 499) == 0);
            tick();
        end
        RESET = 1'b0; indirect = 1'b0; irq = 1'b0; flush = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
